// File: rtl/spi_slave_core_pkg.sv
// spi_slave_core_pkg
// Shared SPI definitions for the SPI target engine: data width, transfer-size
// and lane-mode encodings, the FSM state type and the helpers that turn a
// tsize code into the word's MSB index and bit mask.
// No ports.
package spi_slave_core_pkg;

    localparam int SPI_DATA_WIDTH = 32;

    // transfer size: 8/16/24/32 bits
    localparam logic [1:0] SPI_TSIZE_8  = 2'b00;
    localparam logic [1:0] SPI_TSIZE_16 = 2'b01;
    localparam logic [1:0] SPI_TSIZE_24 = 2'b10;
    localparam logic [1:0] SPI_TSIZE_32 = 2'b11;

    // lane modes; QUAD is treated as STD by the target
    localparam logic [1:0] SPI_MODE_STD  = 2'b00;
    localparam logic [1:0] SPI_MODE_DUAL = 2'b01;
    localparam logic [1:0] SPI_MODE_QUAD = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // index of the word MSB (N-1) for a tsize code
    function automatic logic [4:0] tsize_msb(input logic [1:0] tsize);
        logic [4:0] msb;
        case (tsize)
            SPI_TSIZE_8:  msb = 5'd7;
            SPI_TSIZE_16: msb = 5'd15;
            SPI_TSIZE_24: msb = 5'd23;
            default:      msb = 5'd31;
        endcase
        return msb;
    endfunction

    // ones in bits [msb:0]
    function automatic logic [SPI_DATA_WIDTH-1:0] width_mask(input logic [4:0] msb);
        logic [SPI_DATA_WIDTH-1:0] mask;
        for (int i = 0; i < SPI_DATA_WIDTH; i++) begin
            mask[i] = (i <= int'(msb));
        end
        return mask;
    endfunction

endpackage

// File: rtl/spi_slv_sync.sv
// spi_slv_sync
// Synchronizes the SPI pins into the system clock domain and detects edges on
// the synchronized sck and nss.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   sck_pin, nss_pin      raw serial clock / chip select
//   io_pin[3:0]           raw pad inputs
//   sck, nss, io[3:0]     synchronized levels
//   sck_rise, sck_fall    one-cycle pulses on synchronized sck edges
//   nss_fall, nss_rise    one-cycle pulses on synchronized nss edges
module spi_slv_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck_pin,
    input  logic       nss_pin,
    input  logic [3:0] io_pin,
    output logic       sck,
    output logic       nss,
    output logic [3:0] io,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       nss_fall,
    output logic       nss_rise
);

    logic [SYNC_STAGES-1:0] sck_pipe;
    logic [SYNC_STAGES-1:0] nss_pipe;
    logic [3:0]             io_pipe [SYNC_STAGES];
    logic                   sck_d;
    logic                   nss_d;

    // nss resets deselected so reset release never looks like a select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_pipe <= '0;
            nss_pipe <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) io_pipe[i] <= '0;
            sck_d    <= 1'b0;
            nss_d    <= 1'b1;
        end else begin
            sck_pipe   <= {sck_pipe[SYNC_STAGES-2:0], sck_pin};
            nss_pipe   <= {nss_pipe[SYNC_STAGES-2:0], nss_pin};
            io_pipe[0] <= io_pin;
            for (int i = 1; i < SYNC_STAGES; i++) io_pipe[i] <= io_pipe[i-1];
            sck_d      <= sck;
            nss_d      <= nss;
        end
    end

    assign sck      = sck_pipe[SYNC_STAGES-1];
    assign nss      = nss_pipe[SYNC_STAGES-1];
    assign io       = io_pipe[SYNC_STAGES-1];
    assign sck_rise = sck & ~sck_d;
    assign sck_fall = ~sck & sck_d;
    assign nss_fall = ~nss & nss_d;
    assign nss_rise = nss & ~nss_d;

endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core
// SPI target engine, fully synchronous to clk_i (pins are oversampled).
// Deserializes MOSI (io0) into RX words and serializes TX words onto MISO (io1).
// Optional macro SPI_SLV_DUAL_EN adds mode_i/dir_i and two-lane transfers.
// Ports:
//   clk_i, rst_n_i              system clock, async active-low reset
//   en_i                        core enable
//   cpol_i, cpha_i, lsb_i       SPI mode and bit order (latched at select)
//   tsize_i                     word size 8/16/24/32 (latched at select)
//   spi_sck_i, spi_nss_i        serial clock, chip select (active low)
//   spi_io_in_i/out_o/en_o      pad inputs, outputs, output enables
//   tx_valid_i/tx_data_i/tx_ready_o   TX word stream (ready pulses on consume)
//   rx_valid_o/rx_data_o/rx_ready_i   RX word stream
//   busy_o                      selected and enabled
//   ovr_o, udr_o                RX dropped / TX load with no word
//   mode_i, dir_i               (SPI_SLV_DUAL_EN only) lane mode, direction
//
// state  | meaning
// IDLE   | not selected; pads released, waiting for nss fall with en_i
// ACTIVE | selected; shifting on sck edges, words complete every N samples
module spi_slave_core
    import spi_slave_core_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_i,
    input  logic [1:0]            tsize_i,
`ifdef SPI_SLV_DUAL_EN
    input  logic [1:0]            mode_i,
    input  logic                  dir_i,
`endif
    input  logic                  spi_sck_i,
    input  logic                  spi_nss_i,
    input  logic [3:0]            spi_io_in_i,
    output logic [3:0]            spi_io_out_o,
    output logic [3:0]            spi_io_en_o,
    input  logic                  tx_valid_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  tx_ready_o,
    output logic                  rx_valid_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    input  logic                  rx_ready_i,
    output logic                  busy_o,
    output logic                  ovr_o,
    output logic                  udr_o
);

    logic       sck_s, nss_s, sck_rise, sck_fall, nss_fall, nss_rise;
    logic [3:0] io_s;

    spi_slv_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .sck_pin  (spi_sck_i),
        .nss_pin  (spi_nss_i),
        .io_pin   (spi_io_in_i),
        .sck      (sck_s),
        .nss      (nss_s),
        .io       (io_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .nss_fall (nss_fall),
        .nss_rise (nss_rise)
    );

    state_t state, state_next;
    logic   start, abort;

    logic                  cpol_q, cpha_q, lsb_q;
    logic [1:0]            tsize_q;
    logic                  cpol_e, cpha_e, lsb_e;
    logic [1:0]            tsize_e;
    logic                  dual_e, dir_e;
    logic [4:0]            msb, last_cnt, bit_cnt;
    logic [DATA_WIDTH-1:0] mask, tx_sr, rx_sr, rx_next, rx_word, tx_shifted;
    logic                  lead, trail, run, sample_edge, shift_edge;
    logic                  rx_enable, tx_enable, load, word_done, wrap;
    logic                  out1, out0;
    logic [3:0]            io_en;
    logic                  unused_io;

    assign unused_io = ^{io_s[3:2], sck_s, nss_rise};

    // Before selection the live inputs apply, so the select-cycle load sees
    // the mode being latched in that same cycle.
    assign cpol_e  = (state == ST_IDLE) ? cpol_i  : cpol_q;
    assign cpha_e  = (state == ST_IDLE) ? cpha_i  : cpha_q;
    assign lsb_e   = (state == ST_IDLE) ? lsb_i   : lsb_q;
    assign tsize_e = (state == ST_IDLE) ? tsize_i : tsize_q;

`ifdef SPI_SLV_DUAL_EN
    logic dual_q, dir_q;
    assign dual_e = (state == ST_IDLE) ? (mode_i == SPI_MODE_DUAL) : dual_q;
    assign dir_e  = (state == ST_IDLE) ? dir_i : dir_q;
`else
    assign dual_e = 1'b0;
    assign dir_e  = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en_i && nss_fall) begin
                    state_next = ST_ACTIVE;
                    start      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!en_i || nss_s) begin
                    state_next = ST_IDLE;
                    abort      = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign msb       = tsize_msb(tsize_e);
    assign mask      = width_mask(msb);
    assign last_cnt  = dual_e ? (msb >> 1) : msb;
    assign rx_enable = !(dual_e && dir_e);
    assign tx_enable = !(dual_e && !dir_e);

    assign lead        = cpol_e ? sck_fall : sck_rise;
    assign trail       = cpol_e ? sck_rise : sck_fall;
    assign run         = (state == ST_ACTIVE) && !abort;
    assign sample_edge = run && (cpha_e ? trail : lead);
    assign shift_edge  = run && (cpha_e ? lead : trail);
    assign wrap        = (bit_cnt == last_cnt);
    assign word_done   = sample_edge && wrap && rx_enable;
    assign load        = tx_enable && ((start && !cpha_i) || (shift_edge && bit_cnt == 5'd0));

    always_comb begin
        rx_next = rx_sr;
        if (lsb_e) begin
            if (dual_e) begin
                rx_next            = rx_sr >> 2;
                rx_next[msb]       = io_s[1];
                rx_next[msb-5'd1]  = io_s[0];
            end else begin
                rx_next      = rx_sr >> 1;
                rx_next[msb] = io_s[0];
            end
        end else begin
            if (dual_e) rx_next = {rx_sr[DATA_WIDTH-3:0], io_s[1], io_s[0]};
            else        rx_next = {rx_sr[DATA_WIDTH-2:0], io_s[0]};
        end
    end

    assign rx_word    = rx_next & mask;
    assign tx_shifted = lsb_e ? (tx_sr >> (dual_e ? 2 : 1)) : (tx_sr << (dual_e ? 2 : 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            tsize_q    <= 2'b00;
`ifdef SPI_SLV_DUAL_EN
            dual_q     <= 1'b0;
            dir_q      <= 1'b0;
`endif
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            tx_ready_o <= 1'b0;
            ovr_o      <= 1'b0;
            udr_o      <= 1'b0;
        end else begin
            tx_ready_o <= 1'b0;
            ovr_o      <= 1'b0;
            udr_o      <= 1'b0;

            if (start) begin
                cpol_q  <= cpol_i;
                cpha_q  <= cpha_i;
                lsb_q   <= lsb_i;
                tsize_q <= tsize_i;
`ifdef SPI_SLV_DUAL_EN
                dual_q  <= (mode_i == SPI_MODE_DUAL);
                dir_q   <= dir_i;
`endif
            end

            if (start || abort) begin
                bit_cnt <= '0;
                rx_sr   <= '0;
            end else if (sample_edge) begin
                bit_cnt <= wrap ? 5'd0 : bit_cnt + 5'd1;
                if (rx_enable) rx_sr <= wrap ? '0 : rx_next;
            end

            // a load replaces the shift on the first shift edge of each word
            if (load) begin
                tx_sr <= tx_valid_i ? (tx_data_i & mask) : '0;
                if (tx_valid_i) tx_ready_o <= 1'b1;
                else            udr_o      <= 1'b1;
            end else if (shift_edge) begin
                tx_sr <= tx_shifted;
            end

            if (word_done) begin
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o  <= rx_word;
                    rx_valid_o <= 1'b1;
                end else begin
                    ovr_o <= 1'b1;
                end
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

    assign out1 = dual_e ? (lsb_e ? tx_sr[1] : tx_sr[msb])
                         : (lsb_e ? tx_sr[0] : tx_sr[msb]);
    assign out0 = dual_e && (lsb_e ? tx_sr[0] : tx_sr[msb-5'd1]);

    assign io_en        = (state != ST_ACTIVE) ? 4'b0000 :
                          dual_e ? (dir_e ? 4'b0011 : 4'b0000) : 4'b0010;
    assign spi_io_en_o  = io_en;
    assign spi_io_out_o = {2'b00, out1, out0} & io_en;
    assign busy_o       = (state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_core.sv
module tb_spi_slave_core;
    import spi_slave_core_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        en_i = 1'b0;
    logic        cpol_i = 1'b0, cpha_i = 1'b0, lsb_i = 1'b0;
    logic [1:0]  tsize_i = 2'b00;
    logic        spi_sck_i = 1'b0, spi_nss_i = 1'b1;
    logic [3:0]  spi_io_in_i = 4'b0;
    logic [3:0]  spi_io_out_o, spi_io_en_o;
    logic        tx_valid_i = 1'b0;
    logic [31:0] tx_data_i = 32'h0;
    logic        tx_ready_o, rx_valid_o, busy_o, ovr_o, udr_o;
    logic [31:0] rx_data_o;
    logic        rx_ready_i = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    int          n_ready = 0, n_udr = 0, n_ovr = 0;
    logic [31:0] rxq[$];
    int          sck_cyc = 0;
    logic        sck_prev = 1'b0;
    logic        rxv_prev = 1'b0;
    int          last_lat = 0;

    spi_slave_core #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_i         (en_i),
        .cpol_i       (cpol_i),
        .cpha_i       (cpha_i),
        .lsb_i        (lsb_i),
        .tsize_i      (tsize_i),
        .spi_sck_i    (spi_sck_i),
        .spi_nss_i    (spi_nss_i),
        .spi_io_in_i  (spi_io_in_i),
        .spi_io_out_o (spi_io_out_o),
        .spi_io_en_o  (spi_io_en_o),
        .tx_valid_i   (tx_valid_i),
        .tx_data_i    (tx_data_i),
        .tx_ready_o   (tx_ready_o),
        .rx_valid_o   (rx_valid_o),
        .rx_data_o    (rx_data_o),
        .rx_ready_i   (rx_ready_i),
        .busy_o       (busy_o),
        .ovr_o        (ovr_o),
        .udr_o        (udr_o)
    );

    always #5 clk_i = ~clk_i;

    // clk_i rising edges since the last sck pin change
    always @(posedge clk_i) begin
        if (spi_sck_i != sck_prev) sck_cyc = 1;
        else                       sck_cyc = sck_cyc + 1;
        sck_prev = spi_sck_i;
    end

    always @(negedge clk_i) begin
        if (tx_ready_o) n_ready = n_ready + 1;
        if (udr_o)      n_udr   = n_udr + 1;
        if (ovr_o)      n_ovr   = n_ovr + 1;
        if (rx_valid_o && !rxv_prev) last_lat = sck_cyc;
        rxv_prev = rx_valid_o;
        if (rx_valid_o && rx_ready_i) rxq.push_back(rx_data_o);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic hp();
        repeat (8) @(negedge clk_i);
    endtask

    task automatic select(input logic cp, input logic ch, input logic lsb, input logic [1:0] tsz);
        cpol_i    = cp;
        cpha_i    = ch;
        lsb_i     = lsb;
        tsize_i   = tsz;
        spi_sck_i = cp;
        hp();
        hp();
        spi_nss_i = 1'b0;
        hp();
    endtask

    task automatic deselect();
        hp();
        spi_nss_i = 1'b1;
        hp();
        hp();
    endtask

    // one word as the master; tx_valid_i is dropped once the word is loaded
    task automatic xfer(input int nbits, input logic [31:0] mosi, output logic [31:0] miso);
        miso = '0;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = lsb_i ? i : nbits - 1 - i;
            if (!cpha_i) begin
                spi_io_in_i[0] = mosi[b];
                hp();
                if (i == 0) tx_valid_i = 1'b0;
                miso[b]   = spi_io_out_o[1];
                spi_sck_i = ~cpol_i;
                hp();
                spi_sck_i = cpol_i;
            end else begin
                spi_sck_i      = ~cpol_i;
                spi_io_in_i[0] = mosi[b];
                hp();
                if (i == 0) tx_valid_i = 1'b0;
                miso[b]   = spi_io_out_o[1];
                spi_sck_i = cpol_i;
                hp();
            end
        end
    endtask

    initial begin
        logic [31:0] miso;
        int q0, r0, u0, o0;
        logic [31:0] words [3];
        words[0] = 32'h1111;
        words[1] = 32'h2222;
        words[2] = 32'h3333;

        repeat (4) @(negedge clk_i);
        check("reset io_en", {28'h0, spi_io_en_o}, 32'h0);
        check("reset io_out", {28'h0, spi_io_out_o}, 32'h0);
        check("reset rx_valid", {31'h0, rx_valid_o}, 32'h0);
        check("reset rx_data", rx_data_o, 32'h0);
        check("reset busy", {31'h0, busy_o}, 32'h0);
        check("reset pulses", {29'h0, tx_ready_o, ovr_o, udr_o}, 32'h0);
        rst_n_i = 1'b1;
        en_i    = 1'b1;
        repeat (4) @(negedge clk_i);

        // mode 0, MSB first, 8 bit
        q0 = rxq.size();
        r0 = n_ready;
        tx_data_i  = 32'h3C;
        tx_valid_i = 1'b1;
        select(1'b0, 1'b0, 1'b0, SPI_TSIZE_8);
        check("m0 busy", {31'h0, busy_o}, 32'h1);
        check("m0 io_en", {28'h0, spi_io_en_o}, 32'h2);
        xfer(8, 32'hA5, miso);
        deselect();
        check("m0 rx count", 32'(rxq.size() - q0), 32'd1);
        if (rxq.size() > q0) check("m0 rx data", rxq[q0], 32'h0000_00A5);
        check("m0 miso", miso, 32'h3C);
        check("m0 tx_ready", 32'(n_ready - r0), 32'd1);
        check("m0 latency", 32'(last_lat), 32'd3);
        check("idle busy", {31'h0, busy_o}, 32'h0);
        check("idle io_en", {28'h0, spi_io_en_o}, 32'h0);

        // mode 3, LSB first, 32 bit
        q0 = rxq.size();
        tx_data_i  = 32'hDEAD_BEEF;
        tx_valid_i = 1'b1;
        select(1'b1, 1'b1, 1'b1, SPI_TSIZE_32);
        xfer(32, 32'h1234_5678, miso);
        deselect();
        check("m3 rx count", 32'(rxq.size() - q0), 32'd1);
        if (rxq.size() > q0) check("m3 rx data", rxq[q0], 32'h1234_5678);
        check("m3 miso", miso, 32'hDEAD_BEEF);

        // modes 1 and 2, 16 bit, three words back to back
        for (int m = 1; m <= 2; m++) begin
            q0 = rxq.size();
            select(m == 2, m == 1, 1'b0, SPI_TSIZE_16);
            for (int w = 0; w < 3; w++) xfer(16, words[w], miso);
            deselect();
            check($sformatf("m%0d b2b count", m), 32'(rxq.size() - q0), 32'd3);
            for (int w = 0; w < 3; w++)
                if (rxq.size() > q0 + w)
                    check($sformatf("m%0d b2b word%0d", m, w), rxq[q0 + w], words[w]);
        end

        // RX overrun: consumer stalled over two words
        o0 = n_ovr;
        rx_ready_i = 1'b0;
        select(1'b0, 1'b0, 1'b0, SPI_TSIZE_8);
        xfer(8, 32'h01, miso);
        xfer(8, 32'h02, miso);
        deselect();
        check("ovr rx data", rx_data_o, 32'h01);
        check("ovr rx valid", {31'h0, rx_valid_o}, 32'h1);
        check("ovr pulses", 32'(n_ovr - o0), 32'd1);
        rx_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("ovr drained", {31'h0, rx_valid_o}, 32'h0);

        // TX underrun, mode 1
        u0 = n_udr;
        r0 = n_ready;
        tx_valid_i = 1'b0;
        tx_data_i  = 32'hFF;
        select(1'b0, 1'b1, 1'b0, SPI_TSIZE_8);
        xfer(8, 32'h5A, miso);
        deselect();
        check("udr miso", miso, 32'h0);
        check("udr pulses", 32'(n_udr - u0), 32'd1);
        check("udr tx_ready", 32'(n_ready - r0), 32'd0);

        // abort after 5 bits, then a full word
        q0 = rxq.size();
        o0 = n_ovr;
        select(1'b0, 1'b0, 1'b0, SPI_TSIZE_16);
        xfer(5, 32'h1F, miso);
        deselect();
        check("abort no rx", 32'(rxq.size() - q0), 32'd0);
        select(1'b0, 1'b0, 1'b0, SPI_TSIZE_16);
        xfer(16, 32'hBEEF, miso);
        deselect();
        check("abort next count", 32'(rxq.size() - q0), 32'd1);
        if (rxq.size() > q0) check("abort next word", rxq[q0], 32'h0000_BEEF);
        check("abort no ovr", 32'(n_ovr - o0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
- SPI target (slave) engine: the other end of the SPI master link.
- An external master drives sck/nss/MOSI; this block deserializes MOSI into RX words and serializes TX words onto MISO.
- Sits between the chip pads and a register/FIFO front-end via valid/ready streams.
- Fully synchronous to clk_i: SPI pins are oversampled; no sck clock domain.

Parameters:
- DATA_WIDTH, 32, max word width; must equal the shared SPI data width.
- SYNC_STAGES, 2, synchronizer depth on sck/nss/io inputs (≥2).

Ports:
- clk_i  in  1  system clock; must be ≥4× sck frequency.
- rst_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  core enable; low forces IDLE.
- cpol_i  in  1  sck idle level.
- cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge.
- lsb_i  in  1  1: LSB first.
- tsize_i  in  2  transfer size, shared encoding 00/01/10/11 = 8/16/24/32 bits (N).
- spi_sck_i  in  1  serial clock from master.
- spi_nss_i  in  1  chip select, active low.
- spi_io_in_i  in  4  pad inputs; io0 = MOSI.
- spi_io_out_o  out  4  pad outputs; io1 = MISO.
- spi_io_en_o  out  4  pad output enables.
- tx_valid_i, tx_data_i  in  1, DATA_WIDTH  TX word stream.
- tx_ready_o  out  1  pulses one cycle when a TX word is consumed.
- rx_valid_o, rx_data_o  out  1, DATA_WIDTH  RX word, zero-extended above N.
- rx_ready_i  in  1  RX consumer ready.
- busy_o  out  1  nss active and en_i high.
- ovr_o  out  1  one-cycle pulse: RX word dropped.
- udr_o  out  1  one-cycle pulse: TX load with no word available.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift registers and bit_cnt 0.
- Clocking and tsize:
  - sck, nss and io_in pass through SYNC_STAGES flops, then an edge detector.
  - Leading edge = sck leaving cpol_i level; trailing edge = sck returning to it.
  - Sample edge = leading if cpha_i=0, else trailing; shift edge is the other one.
  - cpol_i, cpha_i, lsb_i and tsize_i are sampled at the nss falling edge and held for the whole selection.
- FSM:
  - IDLE→ACTIVE on synced nss fall with en_i=1.
  - ACTIVE→IDLE on nss rise or en_i=0.
  - No other states; CAPTURE is a one-cycle action flag inside ACTIVE.
- TX load occurs when bit_cnt==0:
  - at the nss fall (cpha_i=0 only);
  - at each shift edge (cpha_i=0: trailing, replaces the shift; cpha_i=1: leading).
  - If tx_valid_i: load tx_data_i[N-1:0] into tx_sr and pulse tx_ready_o.
  - Else: load 0 and pulse udr_o.
- MISO = lsb_i ? tx_sr[0] : tx_sr[N-1].
  - Non-load shift edges shift tx_sr toward the output bit.
  - spi_io_en_o = 4'b0010 in ACTIVE, else 0; spi_io_out_o bits are 0 when not enabled.
- RX path:
  - Each sample edge shifts MOSI into rx_sr: MSB-first shifts left, LSB-first fills from bit N-1 down.
  - bit_cnt increments modulo N.
  - On the Nth sample, bit_cnt wraps to 0 and the word completes.
- Word completion:
  - If rx_valid_o=0 or rx_ready_i=1: rx_data_o ← word and rx_valid_o ← 1.
  - Else keep the old word and pulse ovr_o.
  - rx_valid_o clears on rx_valid_o & rx_ready_i unless a new word completes in the same cycle (the new word wins).
- Latency: rx_valid_o rises SYNC_STAGES+1 clk_i cycles after the Nth sample edge at the pin.
- Back-to-back: nss held low continues with the next word without gaps.
- Abort (nss rise or en_i fall mid-word): partial RX discarded; bit_cnt ← 0; an already-loaded TX word counts as consumed; no ovr/udr pulse.
- Glitch: an nss pulse shorter than SYNC_STAGES cycles may be ignored.

Optional Feature:
SPI_SLV_DUAL_EN
- Defined:
  - Adds mode_i[1:0] (shared STD/DUAL encoding) and dir_i (0 = slave receives, 1 = slave transmits).
  - In DUAL mode, 2 bits move per edge on io[1:0]; bit_cnt counts bit pairs (N/2).
  - dir_i=1: spi_io_en_o=4'b0011 and RX is disabled.
  - dir_i=0: spi_io_en_o=0 and TX loads are suppressed (no udr_o).
  - QUAD encodings behave as STD.
- Undefined: ports absent; STD only.

Decomposition:
- Shared SPI define header: transfer-size and mode encodings, data width, an N-from-tsize helper constant table.
- Sub-module spi_slv_sync: parameterised synchronizer plus sck rise/fall and nss fall/rise pulse outputs.
- FSM, shifters and stream logic stay in spi_slave_core.

Test Plan:
- Mode 0, MSB-first, 8-bit: master sends 0xA5 while tx_data_i=0x3C → rx_data_o=0x000000A5, master receives 0x3C, tx_ready_o pulses once.
- Mode 3, LSB-first, 32-bit: master sends 0x12345678, slave TX 0xDEADBEEF → exact words both ways.
- Modes 1/2, 16-bit, three back-to-back words with nss held low → three rx_valid_o events: 0x1111, 0x2222, 0x3333.
- rx_ready_i held 0 over two 8-bit words (0x01, 0x02) → rx_data_o stays 0x01, ovr_o pulses once.
- tx_valid_i=0 at a load → MISO all zeros, udr_o pulses once.
- nss raised after 5 bits of a 16-bit word, then a full word 0xBEEF → no rx_valid_o for the partial word, next word is 0xBEEF.
